// File: rtl/moldudp64_top.sv
`default_nettype none
// ============================================================================
// Module : moldudp64_top
// Strips the 20-byte MoldUDP64 header and slices the payload into per-message
// beats. Data stays in its original lanes, and a mask marks the message bytes.
// Rev    : 1.0
// ============================================================================
module moldudp64_top #(
  parameter int              AXI_DATA_W  = 64,
  parameter int              AXI_KEEP_W  = AXI_DATA_W / 8,
  parameter int              SID_W       = 80,
  parameter int              SEQ_NUM_W   = 64,
  parameter int              ML_W        = 16,
  parameter logic [ML_W-1:0] EOS_MSG_CNT = 16'hffff
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  udp_axis_tvalid_i,
  input  logic [AXI_KEEP_W-1:0] udp_axis_tkeep_i,
  input  logic [AXI_DATA_W-1:0] udp_axis_tdata_i,
  input  logic                  udp_axis_tlast_i,
  input  logic                  udp_axis_tuser_i,
  output logic                  udp_axis_tready_o,
  output logic                  mold_msg_v_o,
  output logic                  mold_msg_start_o,
  output logic [ML_W-1:0]       mold_msg_len_o,
  output logic [AXI_KEEP_W-1:0] mold_msg_mask_o,
  output logic [AXI_DATA_W-1:0] mold_msg_data_o
);

  // Header geometry: 2 full beats, then lanes 0..3 of beat 2 with the count in lanes 2..3.
  localparam int         c_hdr_bytes     = (SID_W + SEQ_NUM_W + ML_W) / 8;
  localparam int         c_hdr_last_lane = (c_hdr_bytes % AXI_KEEP_W) - 1;
  localparam logic [1:0] c_hdr_beats     = 2'(c_hdr_bytes / AXI_KEEP_W);
  localparam int         c_cnt_lsb       = 8 * (c_hdr_last_lane + 1) - ML_W;
  localparam int         c_lane_w        = $clog2(AXI_KEEP_W);

  typedef enum logic [1:0] {ST_HDR, ST_LEN, ST_PAY, ST_DRAIN} state_t;

  state_t                r_st, w_st;
  logic [1:0]            r_hdr_beat;
  logic [ML_W-1:0]       r_cnt, w_cnt;
  logic [ML_W-1:0]       r_rem, w_rem;
  logic [ML_W-1:0]       r_cur_len, w_cur_len;
  logic [7:0]            r_len_lo, w_len_lo;
  logic                  r_have_lo, w_have_lo;
  logic                  r_pend, w_pend;
  logic [c_lane_w-1:0]   r_lane_off, w_split_lane;
  logic                  r_rdy;
  logic                  r_v, r_start;
  logic [ML_W-1:0]       r_len, w_out_len;
  logic [AXI_KEEP_W-1:0] r_mask, w_mask;
  logic [AXI_DATA_W-1:0] r_data;
  logic                  w_start, w_split;
  logic [7:0]            w_byte;
  logic                  w_go, w_stall, w_emit, w_commit;

  // Walk the lanes of the presented beat in order, starting where a split left off.
  always_comb begin
    w_st         = r_st;
    w_cnt        = r_cnt;
    w_rem        = r_rem;
    w_cur_len    = r_cur_len;
    w_len_lo     = r_len_lo;
    w_have_lo    = r_have_lo;
    w_pend       = r_pend;
    w_mask       = '0;
    w_start      = 1'b0;
    w_out_len    = r_len;
    w_split      = 1'b0;
    w_split_lane = '0;
    w_byte       = '0;
    for (int i = 0; i < AXI_KEEP_W; i++) begin
      w_byte = udp_axis_tdata_i[8*i +: 8];
      if (!w_split && udp_axis_tkeep_i[i] && (i >= int'(r_lane_off))) begin
        case (w_st)
          ST_HDR: begin
            if (r_hdr_beat == c_hdr_beats && i == c_hdr_last_lane) begin
              w_cnt = udp_axis_tdata_i[c_cnt_lsb +: ML_W];
              w_st  = (w_cnt == '0 || w_cnt == EOS_MSG_CNT) ? ST_DRAIN : ST_LEN;
            end
          end
          ST_LEN: begin
            if (!w_have_lo) begin
              w_len_lo  = w_byte;
              w_have_lo = 1'b1;
            end else begin
              w_have_lo = 1'b0;
              w_cur_len = {w_byte, w_len_lo};
              if (w_cur_len == '0) begin
                w_cnt = w_cnt - ML_W'(1);
                w_st  = (w_cnt == '0) ? ST_DRAIN : ST_LEN;
              end else begin
                w_rem  = w_cur_len;
                w_pend = 1'b1;
                w_st   = ST_PAY;
              end
            end
          end
          ST_PAY: begin
            // A second message starting in a beat that already carries bytes forces a split.
            if (w_pend && w_mask != '0) begin
              w_split      = 1'b1;
              w_split_lane = c_lane_w'(i);
            end else begin
              w_mask[i] = 1'b1;
              if (w_pend) w_start = 1'b1;
              w_pend    = 1'b0;
              w_out_len = w_cur_len;
              w_rem     = w_rem - ML_W'(1);
              if (w_rem == '0) begin
                w_cnt = w_cnt - ML_W'(1);
                w_st  = (w_cnt == '0) ? ST_DRAIN : ST_LEN;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign w_go     = udp_axis_tvalid_i && r_rdy;
  assign w_stall  = w_go && w_split && !udp_axis_tuser_i;
  assign w_emit   = w_go && !udp_axis_tuser_i && (w_mask != '0);
  assign w_commit = w_stall || (w_go && !udp_axis_tlast_i && !udp_axis_tuser_i);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_st       <= ST_HDR;
      r_hdr_beat <= '0;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_cur_len  <= '0;
      r_len_lo   <= '0;
      r_have_lo  <= 1'b0;
      r_pend     <= 1'b0;
      r_lane_off <= '0;
      r_rdy      <= 1'b0;
      r_v        <= 1'b0;
      r_start    <= 1'b0;
      r_len      <= '0;
      r_mask     <= '0;
      r_data     <= '0;
    end else begin
      r_rdy   <= 1'b1;
      r_v     <= w_emit;
      r_start <= w_emit && w_start;
      r_mask  <= w_emit ? w_mask : '0;
      if (w_emit) r_len <= w_out_len;
      if (w_go) r_data <= udp_axis_tdata_i;
      if (w_commit) begin
        r_st      <= w_st;
        r_cnt     <= w_cnt;
        r_rem     <= w_rem;
        r_cur_len <= w_cur_len;
        r_len_lo  <= w_len_lo;
        r_have_lo <= w_have_lo;
        r_pend    <= w_pend;
      end
      if (w_stall) begin
        r_lane_off <= w_split_lane;
      end else if (w_go) begin
        r_lane_off <= '0;
        r_hdr_beat <= (w_commit && w_st == ST_HDR) ? r_hdr_beat + 2'd1 : 2'd0;
        if (udp_axis_tlast_i) begin
          r_st      <= ST_HDR;
          r_have_lo <= 1'b0;
          r_pend    <= 1'b0;
        end else if (udp_axis_tuser_i) begin
          r_st <= ST_DRAIN;
        end
      end
    end
  end

  assign udp_axis_tready_o = r_rdy && !w_stall;
  assign mold_msg_v_o      = r_v;
  assign mold_msg_start_o  = r_start;
  assign mold_msg_len_o    = r_len;
  assign mold_msg_mask_o   = r_mask;
  assign mold_msg_data_o   = r_data;

endmodule
`default_nettype wire

// File: tb/tb_moldudp64_top.sv
`default_nettype none
// ============================================================================
// Module : tb_moldudp64_top
// Scoreboard bench for moldudp64_top: expected message beats are queued as
// stimulus is driven and compared against the beats the DUT emits.
// Rev    : 1.0
// ============================================================================
module tb_moldudp64_top;

  typedef struct packed {
    logic        start;
    logic [15:0] len;
    logic [7:0]  mask;
    logic [63:0] data;
  } out_t;

  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic        tvalid = 1'b0;
  logic [7:0]  tkeep = '0;
  logic [63:0] tdata = '0;
  logic        tlast = 1'b0;
  logic        tuser = 1'b0;
  logic        tready;
  logic        msg_v, msg_start;
  logic [15:0] msg_len;
  logic [7:0]  msg_mask;
  logic [63:0] msg_data;

  logic [79:0] sid = 80'hDEADBEEF;
  logic [63:0] seq = 64'hF0F0F0F0F0F0F0F0;

  out_t exp_q[$];
  out_t obs_q[$];
  out_t mon_o;
  int   n_checks = 0;
  int   n_fail = 0;
  int   stall_cnt = 0;

  moldudp64_top dut (
    .clk               (clk),
    .nreset            (nreset),
    .udp_axis_tvalid_i (tvalid),
    .udp_axis_tkeep_i  (tkeep),
    .udp_axis_tdata_i  (tdata),
    .udp_axis_tlast_i  (tlast),
    .udp_axis_tuser_i  (tuser),
    .udp_axis_tready_o (tready),
    .mold_msg_v_o      (msg_v),
    .mold_msg_start_o  (msg_start),
    .mold_msg_len_o    (msg_len),
    .mold_msg_mask_o   (msg_mask),
    .mold_msg_data_o   (msg_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (nreset && msg_v) begin
      mon_o = {msg_start, msg_len, msg_mask, msg_data};
      obs_q.push_back(mon_o);
    end
  end

  function automatic out_t mk(input logic s, input logic [15:0] l, input logic [7:0] m,
                              input logic [63:0] d);
    out_t r;
    r.start = s;
    r.len   = l;
    r.mask  = m;
    r.data  = d;
    return r;
  endfunction

  // Holds the beat until tready is seen high before a rising edge.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           input logic u);
    logic acc;
    @(negedge clk);
    tvalid = 1'b1;
    tdata  = d;
    tkeep  = k;
    tlast  = l;
    tuser  = u;
    acc    = 1'b0;
    for (int t = 0; t < 8 && !acc; t++) begin
      #1;
      acc = tready;
      if (!acc) stall_cnt++;
      @(posedge clk);
      if (!acc) @(negedge clk);
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: tready stayed 0, required 1");
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
    tuser  = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_hdr(input logic [15:0] cnt, input logic [31:0] tail, input logic last);
    send_beat(sid[63:0], 8'hFF, 1'b0, 1'b0);
    send_beat({seq[47:0], sid[79:64]}, 8'hFF, 1'b0, 1'b0);
    send_beat({tail, cnt, seq[63:48]}, 8'hFF, last, 1'b0);
  endtask

  task automatic test_reset();
    #2 nreset = 1'b0;
    #1;
    n_checks++; if (msg_v !== 1'b0)    begin n_fail++; $display("FAIL reset_v: got %0b required 0", msg_v); end
    n_checks++; if (msg_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %0b required 0", msg_start); end
    n_checks++; if (msg_len !== 16'h0)  begin n_fail++; $display("FAIL reset_len: got %h required 0", msg_len); end
    n_checks++; if (msg_mask !== 8'h0)  begin n_fail++; $display("FAIL reset_mask: got %h required 0", msg_mask); end
    n_checks++; if (msg_data !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h required 0", msg_data); end
    n_checks++; if (tready !== 1'b0)    begin n_fail++; $display("FAIL reset_tready: got %0b required 0", tready); end
    repeat (2) @(posedge clk);
    @(negedge clk) nreset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (tready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %0b required 1", tready); end
  endtask

  task automatic test_basic();
    out_t e, o;
    logic [63:0] b2, b4, b6, b7;
    b2 = {16'hFFFF, 16'd16, 16'd3, 16'hF0F0};
    b4 = {16'd8, 48'hBBBB_BBBB_BBBB};
    b6 = {48'hEEEE_EEEE_EEEE, 16'd11};
    b7 = 64'h0000_00FF_FFFF_FFFF;
    stall_cnt = 0;
    exp_q.push_back(mk(1'b1, 16'd16, 8'hC0, b2));
    exp_q.push_back(mk(1'b0, 16'd16, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA));
    exp_q.push_back(mk(1'b0, 16'd16, 8'h3F, b4));
    exp_q.push_back(mk(1'b1, 16'd8,  8'hFF, 64'hDDDD_DDDD_DDDD_DDDD));
    exp_q.push_back(mk(1'b1, 16'd11, 8'hFC, b6));
    exp_q.push_back(mk(1'b0, 16'd11, 8'h1F, b7));
    send_hdr(16'd3, {16'hFFFF, 16'd16}, 1'b0);
    send_beat(64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b0, 1'b0);
    idle(2);
    send_beat(b4, 8'hFF, 1'b0, 1'b0);
    send_beat(64'hDDDD_DDDD_DDDD_DDDD, 8'hFF, 1'b0, 1'b0);
    send_beat(b6, 8'hFF, 1'b0, 1'b0);
    send_beat(b7, 8'h1F, 1'b1, 1'b0);
    idle(3);
    n_checks++; if (stall_cnt !== 0) begin n_fail++; $display("FAIL basic_stalls: got %0d required 0", stall_cnt); end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL basic_count: observed %0d extra beats, required %0d more", obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL basic_beat: got start=%0b len=%0d mask=%h data=%h, required start=%0b len=%0d mask=%h data=%h",
                   o.start, o.len, o.mask, o.data, e.start, e.len, e.mask, e.data);
        end
      end
    end
  endtask

  task automatic test_split();
    out_t e, o;
    logic [63:0] b3;
    b3 = 64'h0000_2222_0002_1111;
    stall_cnt = 0;
    exp_q.push_back(mk(1'b1, 16'd2, 8'h03, b3));
    exp_q.push_back(mk(1'b1, 16'd2, 8'h30, b3));
    send_hdr(16'd3, {16'd2, 16'd0}, 1'b0);
    send_beat(b3, 8'hFF, 1'b1, 1'b0);
    idle(3);
    n_checks++; if (stall_cnt !== 1) begin n_fail++; $display("FAIL split_stalls: got %0d required 1", stall_cnt); end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL split_count: observed %0d extra beats, required %0d more", obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL split_beat: got start=%0b len=%0d mask=%h data=%h, required start=%0b len=%0d mask=%h data=%h",
                   o.start, o.len, o.mask, o.data, e.start, e.len, e.mask, e.data);
        end
      end
    end
  endtask

  // Length 0x0203 has its low byte in lane 7 and its high byte in lane 0; packet is truncated.
  task automatic test_straddle();
    out_t e, o;
    exp_q.push_back(mk(1'b1, 16'd1, 8'h40, {8'h03, 8'h77, 16'h0001, 16'd2, 16'hF0F0}));
    exp_q.push_back(mk(1'b1, 16'h0203, 8'hFE, 64'h3333_3333_3333_3302));
    exp_q.push_back(mk(1'b0, 16'h0203, 8'hFF, 64'h4444_4444_4444_4444));
    send_hdr(16'd2, {8'h03, 8'h77, 16'h0001}, 1'b0);
    send_beat(64'h3333_3333_3333_3302, 8'hFF, 1'b0, 1'b0);
    send_beat(64'h4444_4444_4444_4444, 8'hFF, 1'b1, 1'b0);
    idle(3);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL straddle_count: observed %0d extra beats, required %0d more", obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL straddle_beat: got start=%0b len=%0d mask=%h data=%h, required start=%0b len=%0d mask=%h data=%h",
                   o.start, o.len, o.mask, o.data, e.start, e.len, e.mask, e.data);
        end
      end
    end
  endtask

  task automatic test_tuser();
    out_t e, o;
    exp_q.push_back(mk(1'b1, 16'd16, 8'hC0, {16'hFFFF, 16'd16, 16'd3, 16'hF0F0}));
    send_hdr(16'd3, {16'hFFFF, 16'd16}, 1'b0);
    send_beat(64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b0, 1'b1);
    send_beat(64'hBBBB_BBBB_BBBB_BBBB, 8'hFF, 1'b0, 1'b0);
    send_beat(64'hDDDD_DDDD_DDDD_DDDD, 8'hFF, 1'b1, 1'b0);
    idle(3);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL tuser_count: observed %0d extra beats, required %0d more", obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL tuser_beat: got start=%0b len=%0d mask=%h data=%h, required start=%0b len=%0d mask=%h data=%h",
                   o.start, o.len, o.mask, o.data, e.start, e.len, e.mask, e.data);
        end
      end
    end
  endtask

  task automatic test_eos_zero();
    out_t e, o;
    send_hdr(16'hFFFF, {16'hFFFF, 16'd16}, 1'b0);
    send_beat(64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b1, 1'b0);
    send_hdr(16'd0, {16'hFFFF, 16'd16}, 1'b0);
    send_beat(64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b1, 1'b0);
    idle(3);
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL eos_zero_silent: got %0d output beats, required 0", obs_q.size());
      obs_q.delete();
    end
    exp_q.push_back(mk(1'b1, 16'd2, 8'hC0, {16'h1234, 16'd2, 16'd1, 16'hF0F0}));
    send_hdr(16'd1, {16'h1234, 16'd2}, 1'b1);
    idle(3);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL eos_next_count: observed %0d extra beats, required %0d more", obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL eos_next_beat: got start=%0b len=%0d mask=%h data=%h, required start=%0b len=%0d mask=%h data=%h",
                   o.start, o.len, o.mask, o.data, e.start, e.len, e.mask, e.data);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    out_t e, o;
    logic [63:0] b2;
    b2 = {16'hFFFF, 16'd16, 16'd3, 16'hF0F0};
    exp_q.push_back(mk(1'b1, 16'd16, 8'hC0, b2));
    send_hdr(16'd3, {16'hFFFF, 16'd16}, 1'b0);
    #2;
    n_checks++; if (msg_v !== 1'b1) begin n_fail++; $display("FAIL mid_pre_v: got %0b required 1", msg_v); end
    nreset = 1'b0;
    #1;
    n_checks++; if (msg_v !== 1'b0)     begin n_fail++; $display("FAIL mid_v: got %0b required 0", msg_v); end
    n_checks++; if (msg_start !== 1'b0) begin n_fail++; $display("FAIL mid_start: got %0b required 0", msg_start); end
    n_checks++; if (msg_len !== 16'h0)  begin n_fail++; $display("FAIL mid_len: got %h required 0", msg_len); end
    n_checks++; if (msg_mask !== 8'h0)  begin n_fail++; $display("FAIL mid_mask: got %h required 0", msg_mask); end
    n_checks++; if (msg_data !== 64'h0) begin n_fail++; $display("FAIL mid_data: got %h required 0", msg_data); end
    n_checks++; if (tready !== 1'b0)    begin n_fail++; $display("FAIL mid_tready: got %0b required 0", tready); end
    tvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) nreset = 1'b1;
    exp_q.push_back(mk(1'b1, 16'd16, 8'hC0, b2));
    exp_q.push_back(mk(1'b0, 16'd16, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA));
    exp_q.push_back(mk(1'b0, 16'd16, 8'h3F, {16'd8, 48'hBBBB_BBBB_BBBB}));
    send_hdr(16'd3, {16'hFFFF, 16'd16}, 1'b0);
    send_beat(64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b0, 1'b0);
    send_beat({16'd8, 48'hBBBB_BBBB_BBBB}, 8'hFF, 1'b1, 1'b0);
    idle(3);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL reset_mid_count: observed %0d extra beats, required %0d more", obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL reset_mid_beat: got start=%0b len=%0d mask=%h data=%h, required start=%0b len=%0d mask=%h data=%h",
                   o.start, o.len, o.mask, o.data, e.start, e.len, e.mask, e.data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_split();
    test_straddle();
    test_tuser();
    test_eos_zero();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
